// File: rtl/inter_msg_tx.sv
// inter_msg_tx
//   Transmit stage of the inter-board link. Messages {type, number} pushed by
//   the game controller are queued in a small FIFO and sent to the peer board
//   as two 6-bit beats, each one carried by a 4-phase Request/Ack handshake
//   with a per-beat timeout.
//
//   Beat encoding: beat0 = {1'b1, 2'b00, type}, beat1 = {1'b0, number}.
//   Bit 5 marks the first beat of a message.
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-high reset
//   ctrl_en         1-cycle message push strobe
//   ctrl_msg_type   message type (3 bits)
//   ctrl_number     message payload number (5 bits)
//   Ack_in          peer acknowledge, asynchronous (2-FF synchronised)
//   inter_ready     FIFO not full; a push this cycle is accepted
//   Request_out     handshake request to peer
//   inter_data_out  beat data to peer (6 bits)
//   tx_busy         transmitter active or messages queued
//   tx_done         1-cycle pulse after a message completes normally
//   tx_timeout      1-cycle pulse when a message is aborted
//   overflow        sticky, set by a push while full; cleared only by rst

module inter_msg_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TO_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  input  logic       Ack_in,
  output logic       inter_ready,
  output logic       Request_out,
  output logic [5:0] inter_data_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_timeout,
  output logic       overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    RELEASE
  } state_t;

  // ---------------------------------------------------------------------------
  // Ack synchroniser
  // ---------------------------------------------------------------------------
  logic ack_m;
  logic ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= Ack_in;
      ack_s <= ack_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Message FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // A push while full is dropped even when a pop frees a slot this cycle.
  assign push  = ctrl_en && !full;
  assign head  = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_n = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ctrl_msg_type, ctrl_number};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inter_ready <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count_n;
      inter_ready <= (count_n != CNT_FULL);
      if (ctrl_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_n;
  logic            req_q;
  logic            req_n;
  logic [5:0]      data_q;
  logic [5:0]      data_n;
  logic [4:0]      num_q;
  logic [4:0]      num_n;
  logic            beat_q;
  logic            beat_n;
  logic            abort_q;
  logic            abort_n;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_n;
  logic            done_q;
  logic            done_n;
  logic            tmo_q;
  logic            tmo_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      num_q   <= '0;
      beat_q  <= 1'b0;
      abort_q <= 1'b0;
      to_cnt  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      data_q  <= data_n;
      num_q   <= num_n;
      beat_q  <= beat_n;
      abort_q <= abort_n;
      to_cnt  <= to_cnt_n;
      done_q  <= done_n;
      tmo_q   <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_n    = req_q;
    data_n   = data_q;
    num_n    = num_q;
    beat_n   = beat_q;
    abort_n  = abort_q;
    to_cnt_n = to_cnt;
    done_n   = 1'b0;
    tmo_n    = 1'b0;
    pop      = 1'b0;

    unique case (state)
      IDLE: begin
        // Never start while the peer still holds Ack from a previous beat.
        if (!empty && !ack_s) begin
          pop     = 1'b1;
          data_n  = {1'b1, 2'b00, head[7:5]};
          num_n   = head[4:0];
          beat_n  = 1'b0;
          abort_n = 1'b0;
          state_n = SETUP;
        end
      end

      SETUP: begin
        // Data was driven one cycle earlier, so it is stable before Request.
        req_n    = 1'b1;
        to_cnt_n = '0;
        state_n  = REQ;
      end

      REQ: begin
        if (ack_s) begin
          req_n    = 1'b0;
          to_cnt_n = '0;
          state_n  = RELEASE;
        end else if (to_cnt == TO_LAST) begin
          req_n    = 1'b0;
          abort_n  = 1'b1;
          to_cnt_n = '0;
          state_n  = RELEASE;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end

      RELEASE: begin
        if (!ack_s) begin
          if (!beat_q && !abort_q) begin
            data_n  = {1'b0, num_q};
            beat_n  = 1'b1;
            state_n = SETUP;
          end else begin
            data_n  = '0;
            done_n  = !abort_q;
            tmo_n   = abort_q;
            state_n = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          data_n  = '0;
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign Request_out    = req_q;
  assign inter_data_out = data_q;
  assign tx_done        = done_q;
  assign tx_timeout     = tmo_q;
  assign tx_busy        = (state != IDLE) || !empty;

endmodule

// File: tb/tb_inter_msg_tx.sv
module tb_inter_msg_tx;

  logic       clk;
  logic       rst;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       Ack_in;
  logic       inter_ready;
  logic       Request_out;
  logic [5:0] inter_data_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_timeout;
  logic       overflow;

  inter_msg_tx #(
    .DEPTH  (4),
    .TIMEOUT(16),
    .TO_W   (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_en       (ctrl_en),
    .ctrl_msg_type (ctrl_msg_type),
    .ctrl_number   (ctrl_number),
    .Ack_in        (Ack_in),
    .inter_ready   (inter_ready),
    .Request_out   (Request_out),
    .inter_data_out(inter_data_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_timeout    (tx_timeout),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_beats [$];
  logic [1:0] exp_evts  [$];   // 2'b01 = tx_done, 2'b10 = tx_timeout

  bit peer_on   = 1'b0;
  bit ack_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = full message completes, 1 = beat0 then timeout,
  //       2 = beat0 only (reset mid-handshake), 3 = never transmitted
  task automatic push_msg(input logic [2:0] t, input logic [4:0] n,
                          input bit accept, input int mode);
    if (accept) begin
      if (mode <= 2) exp_beats.push_back({1'b1, 2'b00, t});
      if (mode == 0) begin
        exp_beats.push_back({1'b0, n});
        exp_evts.push_back(2'b01);
      end
      if (mode == 1) exp_evts.push_back(2'b10);
    end
    ctrl_msg_type = t;
    ctrl_number   = n;
    ctrl_en       = 1'b1;
    step();
    ctrl_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (tx_busy && k < 1000) begin
      step();
      k++;
    end
    check(name, {31'b0, tx_busy}, 32'd0);
  endtask

  // Peer model: raises Ack 4 cycles after Request rises, drops it 4 cycles
  // after Request falls. When disabled, Ack follows ack_force.
  initial begin
    int pc;
    pc = 0;
    Ack_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!peer_on) begin
        Ack_in = ack_force;
        pc = 0;
      end else if (Request_out && !Ack_in) begin
        pc++;
        if (pc == 4) begin Ack_in = 1'b1; pc = 0; end
      end else if (!Request_out && Ack_in) begin
        pc++;
        if (pc == 4) begin Ack_in = 1'b0; pc = 0; end
      end else begin
        pc = 0;
      end
    end
  end

  // Monitor: compares every beat at the Request rise, checks data stability
  // while Request is high, and matches every end-of-message pulse.
  logic       prev_req = 1'b0;
  logic [5:0] held     = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (Request_out && !prev_req) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat: unexpected request with data %b", inter_data_out);
        end else begin
          check("beat", {26'b0, inter_data_out}, {26'b0, exp_beats.pop_front()});
        end
        held = inter_data_out;
      end else if (Request_out) begin
        check("data_stable", {26'b0, inter_data_out}, {26'b0, held});
      end
      if (tx_done || tx_timeout) begin
        if (exp_evts.size() == 0) begin
          checks++; errors++;
          $display("FAIL end_event: unexpected done=%0b timeout=%0b", tx_done, tx_timeout);
        end else begin
          check("end_event", {30'b0, tx_timeout, tx_done}, {30'b0, exp_evts.pop_front()});
        end
      end
      prev_req = Request_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    ctrl_en = 1'b0;
    ctrl_msg_type = '0;
    ctrl_number = '0;
    step(); step();

    // Reset state
    check("rst_req",   {31'b0, Request_out}, 32'd0);
    check("rst_data",  {26'b0, inter_data_out}, 32'd0);
    check("rst_ready", {31'b0, inter_ready}, 32'd1);
    check("rst_busy",  {31'b0, tx_busy}, 32'd0);
    check("rst_done",  {31'b0, tx_done}, 32'd0);
    check("rst_tmo",   {31'b0, tx_timeout}, 32'd0);
    check("rst_ovf",   {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    step();

    // Single message with latency checks
    peer_on = 1'b1;
    push_msg(3'b010, 5'd17, 1'b1, 0);
    check("lat_data_n", {26'b0, inter_data_out}, 32'd0);
    step();
    check("lat_beat0",  {26'b0, inter_data_out}, 32'b100010);
    check("lat_req_n1", {31'b0, Request_out}, 32'd0);
    step();
    check("lat_req_n2", {31'b0, Request_out}, 32'd1);
    wait_idle("single_idle");
    check("single_ready", {31'b0, inter_ready}, 32'd1);
    check("single_data0", {26'b0, inter_data_out}, 32'd0);

    // Fill with Ack held high so nothing is popped, then overflow
    peer_on = 1'b0;
    ack_force = 1'b1;
    step(); step(); step(); step();
    push_msg(3'b101, 5'd9,  1'b1, 1);
    check("fill1_ready", {31'b0, inter_ready}, 32'd1);
    push_msg(3'b001, 5'd4,  1'b1, 0);
    push_msg(3'b110, 5'd31, 1'b1, 0);
    check("fill3_ready", {31'b0, inter_ready}, 32'd1);
    push_msg(3'b011, 5'd0,  1'b1, 0);
    check("fill4_ready", {31'b0, inter_ready}, 32'd0);
    check("fill4_ovf",   {31'b0, overflow}, 32'd0);
    check("fill4_req",   {31'b0, Request_out}, 32'd0);
    push_msg(3'b111, 5'd1,  1'b0, 3);
    check("fill5_ovf",   {31'b0, overflow}, 32'd1);
    check("fill5_ready", {31'b0, inter_ready}, 32'd0);

    // Release Ack; push lands on the same edge as the first pop while full
    ack_force = 1'b0;
    step(); step();
    push_msg(3'b010, 5'd2, 1'b0, 3);
    check("full_pop_ready", {31'b0, inter_ready}, 32'd1);
    check("full_pop_ovf",   {31'b0, overflow}, 32'd1);

    // Silent peer: first message times out after 16 cycles of Request
    k = 0;
    while (!Request_out && k < 50) begin step(); k++; end
    check("tmo_req_rise", {31'b0, Request_out}, 32'd1);
    k = 0;
    while (Request_out && k < 100) begin step(); k++; end
    check("tmo_req_len", k, 32'd16);
    k = 0;
    while (!tx_timeout && k < 50) begin step(); k++; end
    check("tmo_pulse", {31'b0, tx_timeout}, 32'd1);
    // Pop of the next message happens on this edge: count 3 stays 3
    push_msg(3'b100, 5'd12, 1'b1, 0);
    check("pop_push_ready", {31'b0, inter_ready}, 32'd1);
    peer_on = 1'b1;
    wait_idle("drain_idle");
    check("drain_ovf",   {31'b0, overflow}, 32'd1);
    check("drain_ready", {31'b0, inter_ready}, 32'd1);

    // Ack held high when a message arrives
    peer_on = 1'b0;
    ack_force = 1'b1;
    step(); step(); step(); step();
    push_msg(3'b011, 5'd21, 1'b1, 0);
    for (int i = 0; i < 6; i++) step();
    check("ackhi_req",  {31'b0, Request_out}, 32'd0);
    check("ackhi_busy", {31'b0, tx_busy}, 32'd1);
    check("ackhi_data", {26'b0, inter_data_out}, 32'd0);
    peer_on = 1'b1;
    ack_force = 1'b0;
    wait_idle("ackhi_idle");

    // Reset while in REQ with two messages queued
    peer_on = 1'b0;
    step(); step(); step(); step();
    push_msg(3'b110, 5'd7,  1'b1, 2);
    push_msg(3'b001, 5'd3,  1'b1, 3);
    push_msg(3'b000, 5'd30, 1'b1, 3);
    k = 0;
    while (!Request_out && k < 50) begin step(); k++; end
    check("mid_req_high", {31'b0, Request_out}, 32'd1);
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("arst_req",   {31'b0, Request_out}, 32'd0);
    check("arst_data",  {26'b0, inter_data_out}, 32'd0);
    check("arst_ready", {31'b0, inter_ready}, 32'd1);
    check("arst_busy",  {31'b0, tx_busy}, 32'd0);
    check("arst_ovf",   {31'b0, overflow}, 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("post_rst_req",  {31'b0, Request_out}, 32'd0);
    check("post_rst_busy", {31'b0, tx_busy}, 32'd0);
    check("beats_left",  exp_beats.size(), 32'd0);
    check("events_left", exp_evts.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
